// File: rtl/shake256_squeeze_reader.sv
`timescale 1ns/1ps
// shake256_squeeze_reader
//
// Sits on the squeeze side of a SHAKE256 core and turns its 1088-bit rate
// blocks into an arbitrary-length stream of 64-bit words.
//
// Flow: a start pulse latches the requested byte count. Each rising edge of
// `squeezed` offers a new rate block on `hash`. The first block of a request
// goes into the active buffer and is sent out lane by lane, lane 0 first. A
// block that arrives while streaming is parked in a one-deep pending buffer.
// A block that arrives while that buffer is already full is dropped and
// flagged with `overflow`.
//
// Ports:
//   clock      system clock, rising edge
//   reset      asynchronous, active-low reset
//   start      one-cycle request strobe, honoured only when idle
//   out_len    requested output length in bytes (latched on start)
//   squeezed   core squeeze flag; a rising edge marks a fresh block
//   hash       core rate block, valid at the squeezed rising edge
//   out_data   output word, first byte in [63:56]
//   out_keep   byte enables, MSB-first; 8'hFF except on a short last word
//   out_valid  out_data/out_keep/out_last valid
//   out_ready  downstream accept
//   out_last   final word of the request
//   done       one-cycle pulse after the last word is accepted
//   overflow   one-cycle pulse when a block is dropped
//   busy       request in progress
module shake256_squeeze_reader #(
    parameter int WORD_W = 64,
    parameter int RATE_W = 1088,
    parameter int LEN_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [LEN_W-1:0]  out_len,
    input  logic              squeezed,
    input  logic [RATE_W-1:0] hash,
    output logic [WORD_W-1:0] out_data,
    output logic [7:0]        out_keep,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              done,
    output logic              overflow,
    output logic              busy
);

    localparam int LANES  = RATE_W / WORD_W;
    localparam int LANE_W = $clog2(LANES);
    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(LANES - 1);
    localparam logic [LEN_W-1:0]  BYTES_PER_WORD = LEN_W'(8);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                squeezed_q;
    logic [RATE_W-1:0]   active_q, active_d;
    logic [RATE_W-1:0]   pending_q, pending_d;
    logic                pend_valid_q, pend_valid_d;
    logic [LANE_W-1:0]   lane_q, lane_d;
    logic [LEN_W-1:0]    remaining_q, remaining_d;

    logic [WORD_W-1:0]   out_data_q, out_data_d;
    logic [7:0]          out_keep_q, out_keep_d;
    logic                out_valid_q, out_valid_d;
    logic                out_last_q, out_last_d;
    logic                done_q, done_d;
    logic                overflow_q, overflow_d;
    logic                busy_q, busy_d;

    logic                sq_rise;
    logic                handshake;
    logic                last_word;
    logic [LEN_W-1:0]    take;
    logic                sq_used;

    // Lane view of the next active buffer, so the registered output word
    // already reflects whatever block/lane the next cycle presents.
    logic [WORD_W-1:0]   next_lanes [LANES];

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign next_lanes[gi] = active_d[RATE_W-1-WORD_W*gi -: WORD_W];
        end
    endgenerate

    assign sq_rise   = squeezed & ~squeezed_q;
    assign handshake = out_valid_q & out_ready;
    assign last_word = (remaining_q <= BYTES_PER_WORD);
    // min(8, remaining): remaining can never underflow.
    assign take      = last_word ? remaining_q : BYTES_PER_WORD;

    always_comb begin
        state_d      = state_q;
        active_d     = active_q;
        pending_d    = pending_q;
        pend_valid_d = pend_valid_q;
        lane_d       = lane_q;
        remaining_d  = remaining_q;
        overflow_d   = 1'b0;
        sq_used      = 1'b0;

        case (state_q)
            IDLE: begin
                // Blocks squeezed while idle are not part of any request.
                if (start) begin
                    if (out_len == '0) begin
                        state_d = DONE;
                    end else begin
                        remaining_d = out_len;
                        state_d     = WAIT;
                    end
                end
            end

            WAIT: begin
                if (sq_rise) begin
                    active_d = hash;
                    lane_d   = '0;
                    state_d  = STREAM;
                end
            end

            STREAM: begin
                if (handshake) begin
                    remaining_d = remaining_q - take;
                    if (last_word) begin
                        state_d = DONE;
                    end else if (lane_q == LANE_LAST) begin
                        if (pend_valid_q) begin
                            active_d     = pending_q;
                            pend_valid_d = 1'b0;
                            lane_d       = '0;
                        end else if (sq_rise) begin
                            // Block lands exactly as the old one runs out:
                            // bypass the pending buffer to avoid a bubble.
                            active_d = hash;
                            lane_d   = '0;
                            sq_used  = 1'b1;
                        end else begin
                            state_d = WAIT;
                        end
                    end else begin
                        lane_d = lane_q + LANE_W'(1);
                    end
                end

                // Pending slot freed this cycle by a promotion can take the
                // new block straight away, hence pend_valid_d not _q.
                if (sq_rise && !sq_used) begin
                    if (!pend_valid_d) begin
                        pending_d    = hash;
                        pend_valid_d = 1'b1;
                    end else begin
                        overflow_d = 1'b1;
                    end
                end
            end

            DONE: begin
                pend_valid_d = 1'b0;
                state_d      = IDLE;
            end

            default: state_d = IDLE;
        endcase

        out_valid_d = (state_d == STREAM);
        out_data_d  = out_valid_d ? next_lanes[lane_d] : '0;
        out_last_d  = out_valid_d && (remaining_d <= BYTES_PER_WORD);
        if (!out_valid_d) begin
            out_keep_d = 8'h00;
        end else if (remaining_d >= BYTES_PER_WORD) begin
            out_keep_d = 8'hFF;
        end else begin
            out_keep_d = ~(8'hFF >> remaining_d[2:0]);
        end
        done_d = (state_d == DONE);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            squeezed_q   <= 1'b0;
            active_q     <= '0;
            pending_q    <= '0;
            pend_valid_q <= 1'b0;
            lane_q       <= '0;
            remaining_q  <= '0;
            out_data_q   <= '0;
            out_keep_q   <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            done_q       <= 1'b0;
            overflow_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            squeezed_q   <= squeezed;
            active_q     <= active_d;
            pending_q    <= pending_d;
            pend_valid_q <= pend_valid_d;
            lane_q       <= lane_d;
            remaining_q  <= remaining_d;
            out_data_q   <= out_data_d;
            out_keep_q   <= out_keep_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            done_q       <= done_d;
            overflow_q   <= overflow_d;
            busy_q       <= busy_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_keep  = out_keep_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign done      = done_q;
    assign overflow  = overflow_q;
    assign busy      = busy_q;

endmodule

// File: doc/shake256_squeeze_reader.md
Name: shake256_squeeze_reader

Overview:
Consumer on the squeeze side of the SHAKE256 core. It captures each 1088-bit rate block the core presents on `hash` when `squeezed` rises. It serializes the requested number of output bytes as 64-bit words on a valid/ready stream, and absorbs one extra squeezed block in a pending buffer. It sits between SHAKE256 and downstream logic that needs arbitrary-length XOF output.

Parameters:
- WORD_W, 64, output word width in bits; fixed at 64.
- RATE_W, 1088, rate block width in bits; LANES = RATE_W/WORD_W = 17.
- LEN_W, 16, width of the requested output length in bytes.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; latches out_len; honoured only in IDLE.
- out_len  in  LEN_W  requested output length in bytes.
- squeezed  in  1  SHAKE256 squeeze flag; a rising edge marks a new hash block.
- hash  in  RATE_W  SHAKE256 rate block; valid at the `squeezed` rising edge.
- out_data  out  WORD_W  output word; first byte in [63:56].
- out_keep  out  8  byte enables, MSB-first; 8'hFF except on the last word.
- out_valid  out  1  out_data/out_keep/out_last valid.
- out_ready  in  1  downstream accept.
- out_last  out  1  marks the final word of the request.
- done  out  1  one-cycle pulse after the last word is accepted.
- overflow  out  1  one-cycle pulse when a block is dropped because both buffers are full.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; all outputs 0.
  - Edge register squeezed_q=0; active buffer and pending buffer invalid; counters 0.
  - Reset mid-operation abandons the request; no done pulse.
- Edge detect: `sq_rise` = squeezed & ~squeezed_q, sampled at the clock edge; squeezed_q <= squeezed every cycle.
- Lane order: lane i = hash[RATE_W-1-64*i -: 64], i = 0..16. Lane 0 is emitted first.
- States:
  - IDLE:
    - start & out_len==0 -> DONE.
    - start & out_len!=0 -> WAIT; remaining <= out_len.
    - sq_rise in IDLE is ignored; nothing is captured.
  - WAIT:
    - sq_rise -> load the active buffer from hash, lane <= 0 -> STREAM.
    - out_valid is high from the cycle after the capturing edge (1-cycle latency).
  - STREAM:
    - out_valid=1; out_data = active lane.
    - out_last = (remaining <= 8).
    - out_keep = remaining>=8 ? 8'hFF : MSB-first mask of `remaining` ones (e.g. 4 -> 8'hF0).
    - Outputs are held stable while out_valid & ~out_ready.
    - On handshake: remaining -= min(8, remaining); lane += 1.
      - If out_last -> DONE.
      - Else if lane==16 (block exhausted):
        - pending valid -> move pending to active, lane <= 0, stay in STREAM with no bubble.
        - pending invalid -> WAIT, out_valid=0.
  - DONE: done=1 for one cycle; pending cleared -> IDLE.
- Capture while streaming: sq_rise in STREAM stores into pending if pending is invalid. If pending is already valid, the block is dropped and overflow pulses.
- Simultaneous block-exhaust handshake and sq_rise with pending invalid: the new block goes directly to the active buffer with no bubble.
- start outside IDLE is ignored.
- Width rules: remaining is LEN_W bits and never underflows. A maximum request of 65535 bytes spans 482 blocks.

Test Plan:
- Reset: hold reset=0 -> all outputs 0, busy=0. Release, pulse start with out_len=136, raise squeezed with hash = 136 bytes of 8'hA3 -> 17 words 64'hA3A3A3A3A3A3A3A3. out_keep=8'hFF on all; out_last only on word 17; done pulses 1 cycle after that handshake.
- Short request: out_len=20, same hash -> 3 words; third word has out_keep=8'hF0 and out_last=1. The remaining 14 lanes are discarded; busy=0 after done.
- Multi-block: out_len=200, out_ready=1.
  - First squeeze -> 17 words, then out_valid=0 in WAIT.
  - Second squeeze with hash = all 8'h5C -> 8 more words 64'h5C5C5C5C5C5C5C5C; out_last on the 8th, keep=8'hFF.
- Back-pressure and pending: out_len=272, out_ready=0.
  - Squeeze twice -> second block held in pending, no overflow.
  - Third squeeze -> overflow pulses once.
  - Then out_ready=1 -> 34 words, block 1 then block 2 with no bubble at lane 16->0; out_data stable during every stall.
- Zero length: start with out_len=0 -> done 1 cycle later; out_valid never asserts.
- Reset mid-operation: assert reset during word 5 of a 136-byte request -> outputs 0 immediately, no done pulse. A fresh start/squeeze then streams correctly from lane 0.
